// File: rtl/wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone decoder and response mux.
// Unmapped or timed-out accesses end in a one-cycle bus error and set a sticky exception.
module wb_interconnect #(
    parameter int unsigned NSLAVES    = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'hc0000000, 32'hb0008000, 32'hb0000000, 32'h00000000},
    parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hffff0000, 32'hffff8000, 32'hffff8000, 32'h00000000},
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_wb_cyc,
    input  logic                          i_wb_stb,
    input  logic                          i_wb_we,
    input  logic [ADDR_WIDTH-1:0]         i_wb_addr,
    input  logic [DATA_WIDTH-1:0]         i_wb_data,
    input  logic [1:0]                    i_wb_width,
    output logic [DATA_WIDTH-1:0]         o_wb_data,
    output logic                          o_wb_ack,
    output logic                          o_wb_stl,
    output logic                          o_wb_err,
    output logic [NSLAVES-1:0]            o_s_cyc,
    output logic [NSLAVES-1:0]            o_s_stb,
    output logic                          o_s_we,
    output logic [ADDR_WIDTH-1:0]         o_s_addr,
    output logic [DATA_WIDTH-1:0]         o_s_data,
    output logic [1:0]                    o_s_width,
    input  logic [NSLAVES*DATA_WIDTH-1:0] i_s_data,
    input  logic [NSLAVES-1:0]            i_s_ack,
    input  logic [NSLAVES-1:0]            i_s_stl,
    input  logic                          i_clr_exc,
    output logic                          o_exception,
    output logic [ADDR_WIDTH-1:0]         o_err_addr
);

    localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    state_t                  r_state;
    logic [SW-1:0]           r_sel;
    logic [15:0]             r_timer;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic [ADDR_WIDTH-1:0]   r_err_addr;
    logic                    r_exc;

    logic [NSLAVES-1:0]      w_match;
    logic [NSLAVES-1:0]      w_idx_oh;
    logic [NSLAVES-1:0]      w_sel_oh;
    logic                    w_hit;
    logic [SW-1:0]           w_idx;
    logic                    w_idx_stl;
    logic                    w_sel_ack;
    logic [DATA_WIDTH-1:0]   w_sel_data;

    assign o_s_we      = i_wb_we;
    assign o_s_addr    = i_wb_addr;
    assign o_s_data    = i_wb_data;
    assign o_s_width   = i_wb_width;
    assign o_exception = r_exc;
    assign o_err_addr  = r_err_addr;

    // Descending scan so the lowest matching port is the one left in w_idx.
    always_comb begin
        w_match = '0;
        w_hit   = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NSLAVES; k++) begin
            if (SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH] != '0 &&
                (i_wb_addr & SLAVE_MASK[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLAVE_BASE[k*ADDR_WIDTH +: ADDR_WIDTH])
                w_match[k] = 1'b1;
        end
        for (int unsigned k = NSLAVES; k > 0; k--) begin
            if (w_match[k-1]) begin
                w_hit = 1'b1;
                w_idx = SW'(k - 1);
            end
        end
    end

    always_comb begin
        w_idx_oh   = '0;
        w_sel_oh   = '0;
        w_idx_stl  = 1'b0;
        w_sel_ack  = 1'b0;
        w_sel_data = '0;
        for (int unsigned k = 0; k < NSLAVES; k++) begin
            if (w_idx == SW'(k)) begin
                w_idx_oh[k] = w_hit;
                w_idx_stl   = i_s_stl[k];
            end
            if (r_sel == SW'(k)) begin
                w_sel_oh[k] = 1'b1;
                w_sel_ack   = i_s_ack[k];
                w_sel_data  = i_s_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        o_s_cyc   = '0;
        o_s_stb   = '0;
        o_wb_stl  = 1'b0;
        o_wb_ack  = 1'b0;
        o_wb_err  = 1'b0;
        o_wb_data = '0;
        case (r_state)
            S_IDLE: begin
                o_s_cyc  = {NSLAVES{i_wb_cyc}} & w_match;
                o_s_stb  = {NSLAVES{i_wb_cyc & i_wb_stb}} & w_idx_oh;
                o_wb_stl = w_hit & w_idx_stl;
            end
            S_WAIT: begin
                o_s_cyc  = {NSLAVES{i_wb_cyc}} & w_sel_oh;
                o_wb_stl = 1'b1;
                if (i_wb_cyc && w_sel_ack) begin
                    o_wb_ack  = 1'b1;
                    o_wb_data = w_sel_data;
                end
            end
            S_ERR: begin
                o_wb_err = 1'b1;
                o_wb_stl = 1'b1;
            end
            default: ;
        endcase
        // Strobes and responses are suppressed while reset is asserted.
        if (!reset) begin
            o_s_cyc   = '0;
            o_s_stb   = '0;
            o_wb_ack  = 1'b0;
            o_wb_err  = 1'b0;
            o_wb_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_timer    <= '0;
            r_req_addr <= '0;
            r_err_addr <= '0;
            r_exc      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_wb_cyc && i_wb_stb) begin
                        if (!w_hit) begin
                            r_err_addr <= i_wb_addr;
                            r_state    <= S_ERR;
                        end else if (!w_idx_stl) begin
                            r_sel      <= w_idx;
                            r_timer    <= '0;
                            r_req_addr <= i_wb_addr;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 16'd1;
                    if (!i_wb_cyc || w_sel_ack) begin
                        r_state <= S_IDLE;
                    end else if (r_timer == 16'(TIMEOUT - 1)) begin
                        r_err_addr <= r_req_addr;
                        r_state    <= S_ERR;
                    end
                end
                S_ERR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (r_state == S_ERR)
                r_exc <= 1'b1;
            else if (i_clr_exc)
                r_exc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect; a negedge monitor pops expected responses
// from a scoreboard queue whenever the master sees ack or err.
module tb_wb_interconnect;

    logic         clk = 1'b0;
    logic         reset;
    logic         cyc, stb, we;
    logic [31:0]  addr, wdata;
    logic [1:0]   width;
    logic [31:0]  m_data;
    logic         m_ack, m_stl, m_err;
    logic [3:0]   s_cyc, s_stb;
    logic         s_we;
    logic [31:0]  s_addr, s_wdata;
    logic [1:0]   s_width;
    logic [127:0] s_data;
    logic [3:0]   s_ack, s_stl;
    logic         clr_exc;
    logic         exc;
    logic [31:0]  err_addr;

    typedef struct {
        bit          is_err;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    wb_interconnect #(
        .NSLAVES   (4),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_width (width),
        .o_wb_data  (m_data),
        .o_wb_ack   (m_ack),
        .o_wb_stl   (m_stl),
        .o_wb_err   (m_err),
        .o_s_cyc    (s_cyc),
        .o_s_stb    (s_stb),
        .o_s_we     (s_we),
        .o_s_addr   (s_addr),
        .o_s_data   (s_wdata),
        .o_s_width  (s_width),
        .i_s_data   (s_data),
        .i_s_ack    (s_ack),
        .i_s_stl    (s_stl),
        .i_clr_exc  (clr_exc),
        .o_exception(exc),
        .o_err_addr (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [31:0] val);
        exp_t e;
        e.is_err = is_err;
        e.val    = val;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every master-visible response must have been predicted.
    always @(negedge clk) begin : sb
        exp_t e;
        if (m_ack || m_err) begin
            chk("sb_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_kind", {62'd0, m_err, m_ack}, e.is_err ? 64'd2 : 64'd1);
                if (e.is_err)
                    chk("sb_err_addr", 64'(err_addr), 64'(e.val));
                else
                    chk("sb_rdata", 64'(m_data), 64'(e.val));
            end
        end
    end

    logic [31:0] dec_addr [5];
    logic [3:0]  dec_exp  [5];

    initial begin
        dec_addr = '{32'hb0007ffc, 32'hb0008000, 32'hc000fffc, 32'hc0010000, 32'h00000000};
        dec_exp  = '{4'b0010,      4'b0100,      4'b1000,      4'b0000,      4'b0000};

        reset = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; width = 2'b00;
        s_ack = '0; s_stl = '0; clr_exc = 1'b0;
        for (int k = 0; k < 4; k++) s_data[k*32 +: 32] = 32'h11111111 * (k + 1);

        // Reset state, with a request held on the bus during reset
        tick();
        cyc = 1'b1; stb = 1'b1; addr = 32'hb0000010;
        #1;
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc), 64'd0);
        tick();
        chk("rst_exc", 64'(exc), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
        chk("rst_ack_err", {62'd0, m_ack, m_err}, 64'd0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        reset = 1'b1;

        // Decode boundaries via o_s_cyc with no strobe
        tick();
        cyc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr = dec_addr[i];
            #1;
            chk("decode_cyc", 64'(s_cyc), 64'(dec_exp[i]));
        end
        cyc = 1'b0;

        // Read slave 1, ack two cycles after the strobe
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'hb0000010;
        push(1'b0, 32'hdeadbeef);
        #1;
        chk("rd_s_stb", 64'(s_stb), 64'b0010);
        chk("rd_stl", 64'(m_stl), 64'd0);
        tick();
        stb = 1'b0;
        #1;
        chk("rd_wait_s_stb", 64'(s_stb), 64'd0);
        chk("rd_wait_s_cyc", 64'(s_cyc), 64'b0010);
        chk("rd_wait_stl", 64'(m_stl), 64'd1);
        chk("rd_wait_noack", {62'd0, m_ack, m_err}, 64'd0);
        chk("rd_wait_data0", 64'(m_data), 64'd0);
        tick();
        s_ack = 4'b0010; s_data[32 +: 32] = 32'hdeadbeef;
        #1;
        chk("rd_ack", 64'(m_ack), 64'd1);
        chk("rd_data", 64'(m_data), 64'hdeadbeef);
        tick();
        s_ack = '0; cyc = 1'b0;
        #1;
        chk("rd_after_ack", 64'(m_ack), 64'd0);

        // Write slave 3 with three stall cycles, ack in the first WAIT cycle
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'hc0000000;
        wdata = 32'h12345678; width = 2'b10; s_stl = 4'b1000;
        s_data[96 +: 32] = 32'h5a5a0000;
        push(1'b0, 32'h5a5a0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wr_stall_stl", 64'(m_stl), 64'd1);
            chk("wr_stall_s_stb", 64'(s_stb), 64'b1000);
            tick();
        end
        s_stl = '0;
        #1;
        chk("wr_accept_stl", 64'(m_stl), 64'd0);
        chk("wr_accept_s_stb", 64'(s_stb), 64'b1000);
        chk("wr_bcast", {s_we, s_width, s_addr, s_wdata}, {1'b1, 2'b10, 32'hc0000000, 32'h12345678});
        chk("wr_no_early_ack", 64'(m_ack), 64'd0);
        tick();
        stb = 1'b0; s_ack = 4'b1000;
        #1;
        chk("wr_ack", 64'(m_ack), 64'd1);
        tick();
        s_ack = '0; cyc = 1'b0; we = 1'b0;

        // Unmapped access, then clear
        tick();
        cyc = 1'b1; stb = 1'b1; addr = 32'hd0000004;
        push(1'b1, 32'hd0000004);
        #1;
        chk("um_s_stb", 64'(s_stb), 64'd0);
        chk("um_s_cyc", 64'(s_cyc), 64'd0);
        tick();
        stb = 1'b0;
        #1;
        chk("um_err", 64'(m_err), 64'd1);
        chk("um_err_stl", 64'(m_stl), 64'd1);
        chk("um_exc_not_yet", 64'(exc), 64'd0);
        tick();
        #1;
        chk("um_err_once", 64'(m_err), 64'd0);
        chk("um_exc", 64'(exc), 64'd1);
        chk("um_err_addr", 64'(err_addr), 64'hd0000004);
        clr_exc = 1'b1;
        tick();
        clr_exc = 1'b0;
        #1;
        chk("clr_exc", 64'(exc), 64'd0);

        // Set wins over a simultaneous clear
        tick();
        stb = 1'b1; addr = 32'he0000000;
        push(1'b1, 32'he0000000);
        tick();
        stb = 1'b0; clr_exc = 1'b1;
        tick();
        clr_exc = 1'b0;
        #1;
        chk("set_wins", 64'(exc), 64'd1);
        clr_exc = 1'b1;
        tick();
        clr_exc = 1'b0; cyc = 1'b0;

        // Timeout on slave 2 (TIMEOUT = 8)
        tick();
        cyc = 1'b1; stb = 1'b1; addr = 32'hb0008010;
        push(1'b1, 32'hb0008010);
        #1;
        chk("to_s_stb", 64'(s_stb), 64'b0100);
        tick();
        stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to_no_err_yet", 64'(m_err), 64'd0);
            tick();
        end
        #1;
        chk("to_err", 64'(m_err), 64'd1);
        chk("to_err_addr", 64'(err_addr), 64'hb0008010);
        tick();
        #1;
        chk("to_exc", 64'(exc), 64'd1);
        chk("to_idle_stl", 64'(m_stl), 64'd0);
        chk("to_idle_s_cyc", 64'(s_cyc), 64'b0100);
        cyc = 1'b0; clr_exc = 1'b1;
        tick();
        clr_exc = 1'b0;

        // Spurious ack from a non-selected slave, and acks in IDLE
        s_ack = 4'b1111;
        #1;
        chk("idle_ack_ignored", 64'(m_ack), 64'd0);
        s_ack = '0;
        tick();
        cyc = 1'b1; stb = 1'b1; addr = 32'hb0000020;
        push(1'b0, 32'hcafef00d);
        tick();
        stb = 1'b0; s_ack = 4'b0100; s_data[64 +: 32] = 32'hbadbadba;
        #1;
        chk("spur_no_ack", 64'(m_ack), 64'd0);
        chk("spur_data0", 64'(m_data), 64'd0);
        tick();
        s_ack = '0;
        tick();
        s_ack = 4'b0010; s_data[32 +: 32] = 32'hcafef00d;
        #1;
        chk("spur_real_ack", 64'(m_ack), 64'd1);
        chk("spur_real_data", 64'(m_data), 64'hcafef00d);
        tick();
        s_ack = '0; cyc = 1'b0;

        // Master abort: cyc drops in WAIT together with a slave ack
        tick();
        cyc = 1'b1; stb = 1'b1; addr = 32'hb0000050;
        tick();
        stb = 1'b0; cyc = 1'b0; s_ack = 4'b0010;
        #1;
        chk("abort_no_ack", 64'(m_ack), 64'd0);
        tick();
        s_ack = '0; cyc = 1'b1;
        #1;
        chk("abort_idle_stl", 64'(m_stl), 64'd0);
        cyc = 1'b0;

        // Reset while in WAIT, late ack afterwards
        tick();
        cyc = 1'b1; stb = 1'b1; addr = 32'hb0000030;
        tick();
        stb = 1'b0;
        #1;
        chk("rw_in_wait", 64'(m_stl), 64'd1);
        reset = 1'b0;
        #1;
        chk("rw_rst_s_cyc", 64'(s_cyc), 64'd0);
        tick();
        reset = 1'b1; s_ack = 4'b0010;
        #1;
        chk("rw_late_ack", 64'(m_ack), 64'd0);
        chk("rw_idle_stl", 64'(m_stl), 64'd0);
        chk("rw_err_addr", 64'(err_addr), 64'd0);
        chk("rw_exc", 64'(exc), 64'd0);
        tick();
        s_ack = '0; cyc = 1'b0;

        // Fresh request after reset completes normally
        tick();
        cyc = 1'b1; stb = 1'b1; addr = 32'hb0000040;
        push(1'b0, 32'h0badf00d);
        tick();
        stb = 1'b0; s_ack = 4'b0010; s_data[32 +: 32] = 32'h0badf00d;
        #1;
        chk("post_rst_ack", 64'(m_ack), 64'd1);
        tick();
        s_ack = '0; cyc = 1'b0;

        tick();
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
- Parametrised single-master, N-slave Wishbone (pipelined) address decoder and response multiplexer for the SoC top.
- Replaces the ad-hoc per-slave enables and the shared ack/stall/data wires.
- Routes each master request to exactly one slave by base/mask match and multiplexes that slave's data, ack and stall back to the master.
- Terminates unmapped accesses and hung slaves with a bus error, and raises a sticky exception to the CPU.

Parameters:
- NSLAVES, 4, number of slave ports (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SLAVE_BASE, {32'hc0000000,32'hb0008000,32'hb0000000,32'h00000000}, packed NSLAVES*ADDR_WIDTH bases; slave k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- SLAVE_MASK, {32'hffff0000,32'hffff8000,32'hffff8000,32'h00000000}, packed masks; mask 0 = port disabled
- TIMEOUT, 255, cycles in WAIT without ack before error (1..65535)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_wb_cyc  in  1  master cycle
- i_wb_stb  in  1  master strobe
- i_wb_we  in  1  master write enable
- i_wb_addr  in  ADDR_WIDTH  master address
- i_wb_data  in  DATA_WIDTH  master write data
- i_wb_width  in  2  access width, passed through
- o_wb_data  out  DATA_WIDTH  read data to master
- o_wb_ack  out  1  ack to master
- o_wb_stl  out  1  stall to master
- o_wb_err  out  1  bus error to master
- o_s_cyc  out  NSLAVES  per-slave cycle
- o_s_stb  out  NSLAVES  per-slave strobe
- o_s_we, o_s_addr, o_s_data, o_s_width  out  1/ADDR_WIDTH/DATA_WIDTH/2  broadcast copies of master signals
- i_s_data  in  NSLAVES*DATA_WIDTH  packed slave read data
- i_s_ack  in  NSLAVES  slave acks
- i_s_stl  in  NSLAVES  slave stalls
- i_clr_exc  in  1  clears sticky exception
- o_exception  out  1  sticky error flag
- o_err_addr  out  ADDR_WIDTH  address of the most recent errored access

Behaviour:
- Decode: match[k] = (i_wb_addr & MASK[k]) == BASE[k] with MASK[k] != 0. The lowest matching k wins; any match sets hit.
- State IDLE (reset state):
  - o_s_cyc[k] = i_wb_cyc & match[k]; o_s_stb[k] = i_wb_cyc & i_wb_stb & sel-match[k].
  - o_wb_stl = hit ? i_s_stl[k] : 0.
  - Accepted request (cyc & stb & hit & !i_s_stl[k]): latch sel = k, clear timer, go to WAIT.
  - cyc & stb & !hit: latch o_err_addr = i_wb_addr, go to ERR. No slave strobe is issued.
- State WAIT:
  - o_s_cyc = one-hot sel (gated by i_wb_cyc); o_s_stb = 0; o_wb_stl = 1.
  - Timer increments each cycle.
  - i_s_ack[sel] = 1: o_wb_ack = 1 and o_wb_data = i_s_data[sel] in the same cycle (combinational), next state IDLE.
  - Timer reaches TIMEOUT - 1 without ack: next state ERR, o_err_addr latched from a registered copy of the request address.
  - i_wb_cyc drops: abort to IDLE with no ack or err.
- State ERR: o_wb_err = 1 for exactly one cycle, o_wb_stl = 1, o_exception <= 1, next state IDLE.
- o_wb_data is 0 whenever o_wb_ack = 0.
- Acks from non-selected slaves, and any ack in IDLE or ERR, are ignored and never reach the master.
- Only one transaction is outstanding at a time: a single-cycle accepted read yields ack at the earliest in the cycle after acceptance.
- o_exception: set in ERR, cleared by i_clr_exc. If both occur in the same cycle, set wins.
- Reset (reset = 0 at a clock edge), including mid-transaction:
  - state IDLE, sel 0, timer 0, o_exception 0, o_err_addr 0.
  - All o_s_cyc/o_s_stb, o_wb_ack and o_wb_err are 0 during the reset cycle.
  - A late slave ack after reset is ignored.
- Broadcast outputs (o_s_we, o_s_addr, o_s_data, o_s_width) are combinational copies of the master inputs.

Test Plan:
- Read 0xb0000010; slave 1 acks 2 cycles after stb with data 0xdeadbeef -> o_s_stb = 4'b0010 for one cycle; o_wb_ack pulses with o_wb_data = 0xdeadbeef; no err.
- Write 0xc0000000; slave 3 holds i_s_stl high 3 cycles -> o_wb_stl high for those 3 cycles, o_s_stb[3] held high, acceptance on the 4th cycle, then ack.
- Access 0xd0000004 (unmapped) -> no o_s_stb; o_wb_err pulses the cycle after stb; o_exception = 1; o_err_addr = 0xd0000004. i_clr_exc -> o_exception = 0.
- TIMEOUT = 8; slave 2 never acks -> o_wb_err exactly 8 cycles after acceptance; o_exception = 1; state returns to IDLE.
- In WAIT for slave 1, slave 2 raises a spurious ack -> master sees no ack; slave 1's later ack is delivered normally.
- Reset driven low while in WAIT, slave acks the next cycle -> no o_wb_ack; all outputs at reset values; a new request after reset completes normally.
